// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared state encoding and width helper for the reset sequencer
package clk_rst_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Bits needed to hold 0..max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for a single asynchronous bit
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - PLL-lock qualified staggered reset release with run-time clock enable
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGGER     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CE_DIV      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_locked,
  input  logic               i_sw_rst,
  output logic [N_DOM-1:0]   o_rst,
  output logic               o_ready,
  output logic               o_ce,
  output logic [STATE_W-1:0] o_state
);

  localparam int CNT_W = cnt_width((LOCK_CYCLES > STAGGER) ? LOCK_CYCLES : STAGGER);
  localparam int CE_W  = cnt_width(CE_DIV);
  localparam int IDX_W = cnt_width(N_DOM);

  if (N_DOM < 1 || N_DOM > 8) begin : g_bad_n_dom
    $fatal(1, "clk_rst_seq: N_DOM must be 1..8");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $fatal(1, "clk_rst_seq: LOCK_CYCLES must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $fatal(1, "clk_rst_seq: STAGGER must be >= 1");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "clk_rst_seq: SYNC_STAGES must be 2..4");
  end
  if (CE_DIV < 2) begin : g_bad_ce
    $fatal(1, "clk_rst_seq: CE_DIV must be >= 2");
  end

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [CE_W-1:0]    r_ce_cnt, w_ce_cnt_nxt;
  logic [N_DOM-1:0]   r_rst, w_rst_nxt;
  logic               r_ready, w_ready_nxt;
  logic               w_locked_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_locked),
    .o_q    (w_locked_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_WAIT_LOCK;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_ce_cnt <= '0;
      r_rst    <= '1;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_ce_cnt <= w_ce_cnt_nxt;
      r_rst    <= w_rst_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  // Lock loss outranks a software request; both restart with every domain held.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_ce_cnt_nxt = r_ce_cnt;
    w_rst_nxt    = r_rst;
    w_ready_nxt  = r_ready;
    if (r_state == ST_WAIT_LOCK || !w_locked_s || i_sw_rst) begin
      w_cnt_nxt    = '0;
      w_idx_nxt    = '0;
      w_ce_cnt_nxt = '0;
      w_rst_nxt    = '1;
      w_ready_nxt  = 1'b0;
      w_state_nxt  = w_locked_s ? ST_STABLE : ST_WAIT_LOCK;
    end else begin
      case (r_state)
        ST_STABLE: begin
          if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == CNT_W'(STAGGER - 1)) begin
            w_cnt_nxt = '0;
            for (int i = 0; i < N_DOM; i++) begin
              if (r_idx == IDX_W'(i)) w_rst_nxt[i] = 1'b0;
            end
            if (r_idx == IDX_W'(N_DOM - 1)) begin
              w_state_nxt  = ST_RUN;
              w_idx_nxt    = '0;
              w_ready_nxt  = 1'b1;
              w_ce_cnt_nxt = '0;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          w_ce_cnt_nxt = (r_ce_cnt == CE_W'(CE_DIV - 1)) ? '0 : r_ce_cnt + 1'b1;
        end
        default: w_state_nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  always_comb begin
    o_ce    = (r_state == ST_RUN) && (r_ce_cnt == CE_W'(CE_DIV - 1));
    o_state = r_state;
    o_rst   = r_rst;
    o_ready = r_ready;
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - cycle-stamped scoreboard bench for the reset sequencer
module tb_clk_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       sw_rst;
  logic [2:0] o_rst;
  logic       o_ready;
  logic       o_ce;
  logic [1:0] o_state;

  clk_rst_seq #(
    .N_DOM(3), .LOCK_CYCLES(8), .STAGGER(4), .SYNC_STAGES(2), .CE_DIV(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_locked(locked),
    .i_sw_rst(sw_rst),
    .o_rst   (o_rst),
    .o_ready (o_ready),
    .o_ce    (o_ce),
    .o_state (o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] st;
    logic       ce;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs after edge number base+k, with edge 1 the first one sampling the new stimulus.
  task automatic expect_at(input int k, input logic [2:0] r, input logic rd,
                           input logic [1:0] st, input logic ce, input string nm);
    exp_t e;
    e.cyc = base + k; e.rst = r; e.rdy = rd; e.st = st; e.ce = ce; e.name = nm;
    q.push_back(e);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (o_ce) begin
      n_checks++;
      if (o_state !== 2'd3) begin
        n_errors++;
        $display("FAIL ce_outside_run cyc=%0d state=%0d required=3", cyc, o_state);
      end
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_checks++;
      if (m_e.cyc != cyc ||
          {o_state, o_ready, o_rst, o_ce} !== {m_e.st, m_e.rdy, m_e.rst, m_e.ce}) begin
        n_errors++;
        $display("FAIL %s cyc=%0d got state=%0d ready=%b rst=%b ce=%b required cyc=%0d state=%0d ready=%b rst=%b ce=%b",
                 m_e.name, cyc, o_state, o_ready, o_rst, o_ce,
                 m_e.cyc, m_e.st, m_e.rdy, m_e.rst, m_e.ce);
      end
    end
  end

  initial begin
    rst_n = 1'b0; locked = 1'b0; sw_rst = 1'b0;
    edges(3);
    base = cyc;
    expect_at(0, 3'b111, 1'b0, 2'd0, 1'b0, "reset_state");
    edges(1);
    rst_n = 1'b1;
    edges(2);

    // Power-up lock and full staggered release into RUN.
    base = cyc;
    locked = 1'b1;
    expect_at(2,  3'b111, 1'b0, 2'd0, 1'b0, "sync_latency");
    expect_at(3,  3'b111, 1'b0, 2'd1, 1'b0, "enter_stable");
    expect_at(10, 3'b111, 1'b0, 2'd1, 1'b0, "stable_last");
    expect_at(11, 3'b111, 1'b0, 2'd2, 1'b0, "enter_release");
    expect_at(14, 3'b111, 1'b0, 2'd2, 1'b0, "before_rel0");
    expect_at(15, 3'b110, 1'b0, 2'd2, 1'b0, "rel0");
    expect_at(18, 3'b110, 1'b0, 2'd2, 1'b0, "before_rel1");
    expect_at(19, 3'b100, 1'b0, 2'd2, 1'b0, "rel1");
    expect_at(22, 3'b100, 1'b0, 2'd2, 1'b0, "before_rel2");
    expect_at(23, 3'b000, 1'b1, 2'd3, 1'b0, "rel2_run");
    expect_at(25, 3'b000, 1'b1, 2'd3, 1'b0, "ce_low");
    expect_at(26, 3'b000, 1'b1, 2'd3, 1'b1, "ce_first");
    expect_at(27, 3'b000, 1'b1, 2'd3, 1'b0, "ce_one_cycle");
    expect_at(30, 3'b000, 1'b1, 2'd3, 1'b1, "ce_second");
    edges(31);

    // Software re-sequence from RUN.
    base = cyc;
    sw_rst = 1'b1;
    expect_at(1,  3'b111, 1'b0, 2'd1, 1'b0, "sw_rst_stable");
    expect_at(8,  3'b111, 1'b0, 2'd1, 1'b0, "sw_stable_last");
    expect_at(9,  3'b111, 1'b0, 2'd2, 1'b0, "sw_release");
    expect_at(12, 3'b111, 1'b0, 2'd2, 1'b0, "sw_before_rel0");
    expect_at(13, 3'b110, 1'b0, 2'd2, 1'b0, "sw_rel0");
    expect_at(17, 3'b100, 1'b0, 2'd2, 1'b0, "sw_rel1");
    edges(1);
    sw_rst = 1'b0;
    edges(16);

    // One-edge reset mid-release, then lock loss colliding with a software request.
    base = cyc;
    rst_n = 1'b0;
    expect_at(1,  3'b111, 1'b0, 2'd0, 1'b0, "mid_reset");
    expect_at(3,  3'b111, 1'b0, 2'd0, 1'b0, "resync_wait");
    expect_at(4,  3'b111, 1'b0, 2'd1, 1'b0, "resync_stable");
    expect_at(12, 3'b111, 1'b0, 2'd2, 1'b0, "resync_release");
    expect_at(15, 3'b111, 1'b0, 2'd2, 1'b0, "pre_collide");
    expect_at(16, 3'b111, 1'b0, 2'd0, 1'b0, "loss_beats_sw");
    expect_at(17, 3'b111, 1'b0, 2'd0, 1'b0, "sw_ignored_wait");
    edges(1);
    rst_n = 1'b1;
    edges(12);
    locked = 1'b0;
    edges(2);
    sw_rst = 1'b1;
    edges(1);
    sw_rst = 1'b0;
    edges(2);

    // Lock drop at edge 5 of STABLE, then full re-count after re-lock.
    base = cyc;
    locked = 1'b1;
    expect_at(3, 3'b111, 1'b0, 2'd1, 1'b0, "relock_stable");
    expect_at(6, 3'b111, 1'b0, 2'd1, 1'b0, "drop_pending");
    expect_at(7, 3'b111, 1'b0, 2'd0, 1'b0, "drop_wait_lock");
    edges(4);
    locked = 1'b0;
    edges(5);
    base = cyc;
    locked = 1'b1;
    expect_at(10, 3'b111, 1'b0, 2'd1, 1'b0, "recount_stable");
    expect_at(11, 3'b111, 1'b0, 2'd2, 1'b0, "recount_release");
    expect_at(14, 3'b111, 1'b0, 2'd2, 1'b0, "recount_before");
    expect_at(15, 3'b110, 1'b0, 2'd2, 1'b0, "recount_rel0");
    edges(18);

    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
